div_ctrl: RTL and testbench



---
 rtl/div_ctrl_pkg.sv | 15 +
 rtl/div_ctrl.sv | 136 +++++++++++++
 tb/tb_div_ctrl.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the EX-stage divider sequencer.
//   div_state_e       : sequencer state encoding
//   DIV_WIDTH_DEFAULT : default operand width
package div_ctrl_pkg;

  localparam int DIV_WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;

endpackage

// File: rtl/div_ctrl.sv
// Multi-cycle radix-2 restoring divider sequencer for MIPS DIV/DIVU.
// Holds the pipeline through stallreq_o while iterating and returns
// {remainder, quotient} as a one-cycle pulse for the HI/LO write.
//
// Ports:
//   clk, rst      : core clock, synchronous active-high reset
//   start_i       : divide request from EX, held until ready_o
//   annul_i       : flush; aborts a pending or running divide
//   signed_div_i  : 1 = DIV (two's complement), 0 = DIVU
//   opdata1_i     : dividend (rs)
//   opdata2_i     : divisor (rt)
//   result_o      : {remainder -> HI, quotient -> LO}, zero unless ready_o
//   ready_o       : result valid, one-cycle pulse
//   stallreq_o    : stall request to CTRL
//
// state       | meaning
// DIV_FREE    | idle, samples operands when start_i && !annul_i
// DIV_BY_ZERO | divisor was zero, result forced to 0
// DIV_ON      | one restoring step per clock, WIDTH steps
// DIV_END     | result_o valid, ready_o high, stall released
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               annul_i,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               stallreq_o
);

  localparam int CW = $clog2(WIDTH) + 1;

  div_state_e         state, state_nxt;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH:0]   dividend, dividend_step;
  logic [WIDTH-1:0]   divisor;
  logic [WIDTH:0]     trial;
  logic [WIDTH-1:0]   quot_fix, rem_fix;
  logic [2*WIDTH-1:0] result;
  logic               s1, s2;
  logic               req, last_step, neg1, neg2;

  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic en);
    return en ? (~v + WIDTH'(1)) : v;
  endfunction

  assign req       = start_i && !annul_i;
  assign last_step = (cnt == CW'(WIDTH - 1));
  assign neg1      = signed_div_i && opdata1_i[WIDTH-1];
  assign neg2      = signed_div_i && opdata2_i[WIDTH-1];

  // Partial remainder lives in dividend[2W:W+1]; bit W holds the next
  // dividend bit to bring down, so the trial window is dividend[2W:W].
  always_comb begin
    trial = dividend[2*WIDTH:WIDTH] - {1'b0, divisor};
    if (trial[WIDTH]) dividend_step = {dividend[2*WIDTH-1:0], 1'b0};
    else              dividend_step = {trial[WIDTH-1:0], dividend[WIDTH-1:0], 1'b1};
  end

  // Remainder takes the dividend's sign; quotient negative on sign mismatch.
  assign quot_fix = neg_if(dividend_step[WIDTH-1:0], s1 ^ s2);
  assign rem_fix  = neg_if(dividend_step[2*WIDTH:WIDTH+1], s1);

  always_ff @(posedge clk) begin
    if (rst) state <= DIV_FREE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    stallreq_o = 1'b0;
    case (state)
      DIV_FREE: begin
        stallreq_o = req;
        if (req) state_nxt = (opdata2_i == '0) ? DIV_BY_ZERO : DIV_ON;
      end
      DIV_BY_ZERO: begin
        stallreq_o = 1'b1;
        state_nxt  = annul_i ? DIV_FREE : DIV_END;
      end
      DIV_ON: begin
        stallreq_o = 1'b1;
        if (annul_i)        state_nxt = DIV_FREE;
        else if (last_step) state_nxt = DIV_END;
      end
      DIV_END: state_nxt = DIV_FREE;
      default: state_nxt = DIV_FREE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      dividend <= '0;
      divisor  <= '0;
      s1       <= 1'b0;
      s2       <= 1'b0;
      result   <= '0;
    end else begin
      // result is only non-zero during DIV_END
      result <= '0;
      case (state)
        DIV_FREE: begin
          if (req) begin
            cnt      <= '0;
            s1       <= neg1;
            s2       <= neg2;
            dividend <= {WIDTH'(0), neg_if(opdata1_i, neg1), 1'b0};
            divisor  <= neg_if(opdata2_i, neg2);
          end
        end
        DIV_ON: begin
          if (annul_i) begin
            cnt <= '0;
          end else begin
            dividend <= dividend_step;
            cnt      <= cnt + CW'(1);
            if (last_step) result <= {rem_fix, quot_fix};
          end
        end
        default: ;
      endcase
    end
  end

  assign ready_o  = (state == DIV_END);
  assign result_o = result;

endmodule

// File: tb/tb_div_ctrl.sv
module tb_div_ctrl;

  localparam int WIDTH = 32;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start_i = 1'b0;
  logic               annul_i = 1'b0;
  logic               signed_div_i = 1'b0;
  logic [WIDTH-1:0]   opdata1_i = '0;
  logic [WIDTH-1:0]   opdata2_i = '0;
  logic [2*WIDTH-1:0] result_o;
  logic               ready_o;
  logic               stallreq_o;

  int vectors = 0;
  int miscompares = 0;
  logic [2*WIDTH-1:0] exp_q[$];

  div_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .annul_i(annul_i),
    .signed_div_i(signed_div_i), .opdata1_i(opdata1_i), .opdata2_i(opdata2_i),
    .result_o(result_o), .ready_o(ready_o), .stallreq_o(stallreq_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer division, C-style truncation, remainder
  // follows the dividend; divide by zero defined as all-zero result.
  function automatic logic [63:0] model(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 0) return 64'd0;
    if (sgn) begin
      sa = $signed(a);
      sb = $signed(b);
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Monitor: consumes one expected result per ready pulse.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (ready_o) begin
        if (exp_q.size() == 0) begin
          check("unexpected_ready", 64'(ready_o), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("result", result_o, e);
        end
      end else begin
        check("result_idle_zero", result_o, 64'd0);
      end
    end
  end

  task automatic do_div(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    int lat, cyc;
    bit seen;
    lat = (b == 0) ? 2 : WIDTH + 1;
    @(negedge clk);
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    exp_q.push_back(model(sgn, a, b));
    cyc  = 0;
    seen = 0;
    while (!seen && cyc <= 60) begin
      #1;
      check("stall", 64'(stallreq_o), 64'(cyc < lat));
      if (ready_o) seen = 1;
      else begin
        @(negedge clk);
        cyc++;
        // operands must be ignored once the divide has started
        opdata1_i    = $urandom;
        opdata2_i    = $urandom;
        signed_div_i = 1'($urandom);
      end
    end
    if (!seen) check("ready_timeout", 64'd0, 64'd1);
    else       check("latency", 64'(cyc), 64'(lat));
    start_i = 1'b0;
  endtask

  // Start DIVU 100/3, then annul (use_rst=0) or reset (use_rst=1) in cycle 'at'.
  task automatic do_abort(input bit use_rst, input int at);
    @(negedge clk);
    signed_div_i = 1'b0;
    opdata1_i    = 32'd100;
    opdata2_i    = 32'd3;
    start_i      = 1'b1;
    for (int c = 1; c <= at; c++) @(negedge clk);
    if (use_rst) rst = 1'b1;
    else         annul_i = 1'b1;
    @(negedge clk);
    rst     = 1'b0;
    annul_i = 1'b0;
    start_i = 1'b0;
    #1;
    check("abort_stall", 64'(stallreq_o), 64'd0);
    check("abort_ready", 64'(ready_o), 64'd0);
    check("abort_result", result_o, 64'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      check("abort_no_ready", 64'(ready_o), 64'd0);
    end
  endtask

  initial begin
    logic [31:0] a, b;
    bit sgn;
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, b;
    bit sgn;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_ready", 64'(ready_o), 64'd0);
    check("reset_result", result_o, 64'd0);
    check("reset_stall", 64'(stallreq_o), 64'd0);

    // start blocked by annul in idle
    @(negedge clk);
    start_i = 1'b1;
    annul_i = 1'b1;
    opdata1_i = 32'd9;
    opdata2_i = 32'd3;
    #1;
    check("annul_idle_stall", 64'(stallreq_o), 64'd0);
    @(negedge clk);
    start_i = 1'b0;
    annul_i = 1'b0;
    #1;
    check("annul_idle_ready", 64'(ready_o), 64'd0);

    do_div(1'b0, 32'hFFFF_FFFF, 32'h0000_0010);
    do_div(1'b1, 32'hFFFF_FFF9, 32'h0000_0002);
    do_div(1'b1, 32'h0000_0007, 32'hFFFF_FFFE);
    do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    do_div(1'b0, 32'h0000_0005, 32'h0000_0000);
    do_div(1'b1, 32'hFFFF_FFFB, 32'h0000_0000);
    do_div(1'b0, 32'h0000_0003, 32'h0000_0007);
    do_div(1'b1, 32'h8000_0000, 32'h0000_0001);

    do_abort(1'b0, 10);
    do_div(1'b0, 32'd100, 32'd3);
    do_abort(1'b1, 15);
    do_div(1'b0, 32'd100, 32'd3);

    for (int i = 0; i < 30; i++) begin
      sgn = 1'($urandom);
      a   = $urandom;
      case ($urandom_range(7))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(15)) + 32'd1;
        2:       b = 32'hFFFF_FFFF;
        3:       b = $urandom >> $urandom_range(31);
        default: b = $urandom;
      endcase
      if (b == 0 && $urandom_range(1) == 0) b = 32'd1;
      do_div(sgn, a, b);
    end

    repeat (3) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
